fmr_fault_mgr: RTL and testbench
================================

Name: fmr_fault_mgr

Overview:
- Downstream consumer of the mismatch latch (g/gn pair, XOR compare of redundant x/z copies). It also drives that latch's clear input r.
- On a latched mismatch it pulses r to clear the latch, then watches a window to decide whether the mismatch was transient or persistent.
- Repeated re-assertion escalates to a sticky fault, held until software acknowledges.
- Keeps a saturating fault-event count and flags illegal g/gn encodings.

Parameters:
- THRESH, 3, number of mismatch observations in one episode that declares a fault (legal range 2..15).
- CLR_HOLD, 2, cycles r is held high per clear (1..15).
- WIN, 8, observation window length in cycles after each clear (2..255).
- CNT_W, 8, width of err_cnt.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- g  in  1  mismatch latch output from the upstream latch.
- gn  in  1  complement output from the upstream latch.
- ack  in  1  software acknowledge; single-cycle pulse.
- r  out  1  clear to the upstream latch; registered.
- fault  out  1  persistent mismatch declared; sticky.
- illegal  out  1  {g,gn}=00 seen; sticky.
- hits  out  4  mismatch observations in the current episode.
- err_cnt  out  CNT_W  total fault declarations, saturating.

Behaviour:
- Reset (rst=1 at a posedge):
  - Next cycle: state=IDLE; r, fault, illegal, hits, err_cnt, window counter and hold counter are all 0.
  - Reset overrides every other input, in any state.
- Input decode, sampled at each posedge:
  - 10 = mismatch.
  - 11 = mismatch with clear active (counts as mismatch).
  - 01 = clean.
  - 00 = illegal: sets illegal at that edge in any state; it is not treated as a mismatch.
- IDLE (r=0):
  - Mismatch sampled -> CLEAR; hits=1.
- CLEAR:
  - r=1 for exactly CLR_HOLD cycles, from the edge of entry. g/gn are ignored.
  - After CLR_HOLD cycles -> WAIT; r=0 at that edge; window counter loaded.
- WAIT (r=0), lasts WIN cycles:
  - The first WAIT sample is ignored (settle cycle for the upstream one-cycle register latency).
  - Mismatch on any later sample:
    - If hits+1 >= THRESH -> FAULT; fault=1 and err_cnt+1 on that edge; hits=THRESH.
    - Otherwise -> CLEAR; hits+1.
  - Window expires with no mismatch -> IDLE; hits=0 (transient absorbed).
- FAULT (r=0, fault=1):
  - g/gn ignored except for the illegal check.
  - ack -> CLEAR; fault=0 and hits=1 on that edge, so the latch is cleared and re-observed as a new episode.
- ack handling:
  - ack in any state clears illegal, unless 00 is sampled on the same edge (set wins).
  - ack outside FAULT has no other effect.
- err_cnt saturates at 2^CNT_W-1; no wrap.
- Latency: mismatch sampled at edge k -> r high from edge k through edge k+CLR_HOLD.
- Simultaneous events:
  - rst beats everything.
  - Mismatch and window expiry on the same WAIT edge: the mismatch wins.
- Illegal states: unused FSM encodings recover to IDLE with r=0.

Test Plan:
- Reset: hold rst=1 for 2 cycles with g=1,gn=0 -> r=0, fault=0, hits=0, err_cnt=0, illegal=0; one cycle after release -> r=1.
- Transient: one mismatch, bench latch model with x==z afterwards (THRESH=3, CLR_HOLD=2, WIN=8) -> r high exactly 2 cycles, no reassert, IDLE after 8 WAIT cycles, hits=0, fault=0, err_cnt=0.
- Persistent: bench latch with x!=z held -> r pulses twice (2 cycles each), hits 1->2->3, fault=1 at the third detection, err_cnt=1, r stays 0 in FAULT.
- Ack: in FAULT pulse ack with the mismatch still present -> fault=0 next cycle, r pulse of 2 cycles, fault re-declared after THRESH observations, err_cnt=2.
- Illegal/saturation: drive {g,gn}=00 for one cycle -> illegal=1 and stays 1 until ack. With CNT_W=2 force 5 fault declarations -> err_cnt stays 3.
- Reset mid-operation: assert rst during the second r cycle of CLEAR -> r=0, state IDLE, hits=0, err_cnt=0 on the next cycle.

Source files
------------

// File: rtl/fmr_fault_mgr_if.sv
// rtl/fmr_fault_mgr_if.sv - mismatch latch / fault manager signal bundle
interface fmr_fault_mgr_if #(
   parameter int CNT_W = 8
);
   logic             g;
   logic             gn;
   logic             ack;
   logic             r;
   logic             fault;
   logic             illegal;
   logic [3:0]       hits;
   logic [CNT_W-1:0] err_cnt;

   modport master (
      output g, gn, ack,
      input  r, fault, illegal, hits, err_cnt
   );

   modport slave (
      input  g, gn, ack,
      output r, fault, illegal, hits, err_cnt
   );
endinterface

// File: rtl/fmr_fault_mgr.sv
// rtl/fmr_fault_mgr.sv - clears the mismatch latch, classifies transient vs persistent, escalates to sticky fault
module fmr_fault_mgr #(
   parameter int THRESH   = 3,
   parameter int CLR_HOLD = 2,
   parameter int WIN      = 8,
   parameter int CNT_W    = 8
) (
   input logic           clk,
   input logic           rst,
   fmr_fault_mgr_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      WAIT  = 3'd2,
      FAULT = 3'd3
   } state_t;

   localparam logic [4:0]       THRESH_V = 5'(THRESH);
   localparam logic [3:0]       THRESH_H = 4'(THRESH);
   localparam logic [3:0]       HOLD_V   = 4'(CLR_HOLD);
   localparam logic [7:0]       WIN_V    = 8'(WIN);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   state_t           state;
   logic [3:0]       hold_cnt;
   logic [7:0]       win_cnt;
   logic             r_q;
   logic             fault_q;
   logic             illegal_q;
   logic [3:0]       hits_q;
   logic [CNT_W-1:0] err_cnt_q;

   logic             mismatch;
   logic             enc_bad;
   logic [4:0]       hits_inc;

   // 10 and 11 both mean the latch holds a mismatch; 00 is a broken pair
   assign mismatch = bus.g;
   assign enc_bad  = ~bus.g & ~bus.gn;
   assign hits_inc = {1'b0, hits_q} + 5'd1;

   assign bus.r       = r_q;
   assign bus.fault   = fault_q;
   assign bus.illegal = illegal_q;
   assign bus.hits    = hits_q;
   assign bus.err_cnt = err_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         hold_cnt  <= '0;
         win_cnt   <= '0;
         r_q       <= 1'b0;
         fault_q   <= 1'b0;
         illegal_q <= 1'b0;
         hits_q    <= '0;
         err_cnt_q <= '0;
      end else begin
         if (enc_bad) begin
            illegal_q <= 1'b1;
         end else if (bus.ack) begin
            illegal_q <= 1'b0;
         end

         case (state)
            IDLE: begin
               r_q <= 1'b0;
               if (mismatch) begin
                  state    <= CLEAR;
                  r_q      <= 1'b1;
                  hold_cnt <= 4'd1;
                  hits_q   <= 4'd1;
               end
            end

            CLEAR: begin
               if (hold_cnt >= HOLD_V) begin
                  state    <= WAIT;
                  r_q      <= 1'b0;
                  hold_cnt <= '0;
                  win_cnt  <= 8'd1;
               end else begin
                  hold_cnt <= hold_cnt + 4'd1;
               end
            end

            WAIT: begin
               // win_cnt==1 is the settle sample: the latch still shows pre-clear data
               if (win_cnt != 8'd1 && mismatch) begin
                  if (hits_inc >= THRESH_V) begin
                     state   <= FAULT;
                     fault_q <= 1'b1;
                     hits_q  <= THRESH_H;
                     if (err_cnt_q != CNT_MAX) begin
                        err_cnt_q <= err_cnt_q + 1'b1;
                     end
                  end else begin
                     state    <= CLEAR;
                     r_q      <= 1'b1;
                     hold_cnt <= 4'd1;
                     hits_q   <= hits_inc[3:0];
                  end
               end else if (win_cnt >= WIN_V) begin
                  state  <= IDLE;
                  hits_q <= '0;
               end else begin
                  win_cnt <= win_cnt + 8'd1;
               end
            end

            FAULT: begin
               r_q <= 1'b0;
               if (bus.ack) begin
                  state    <= CLEAR;
                  fault_q  <= 1'b0;
                  r_q      <= 1'b1;
                  hold_cnt <= 4'd1;
                  hits_q   <= 4'd1;
               end
            end

            default: begin
               state    <= IDLE;
               r_q      <= 1'b0;
               fault_q  <= 1'b0;
               hits_q   <= '0;
               hold_cnt <= '0;
               win_cnt  <= '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_fmr_fault_mgr.sv
// tb/tb_fmr_fault_mgr.sv - scoreboard bench for fmr_fault_mgr with a behavioural mismatch latch
module tb_fmr_fault_mgr;
   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   fmr_fault_mgr_if #(.CNT_W(8)) bus0 ();
   fmr_fault_mgr_if #(.CNT_W(2)) bus1 ();

   fmr_fault_mgr #(.THRESH(3), .CLR_HOLD(2), .WIN(8), .CNT_W(8)) u0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   fmr_fault_mgr #(.THRESH(3), .CLR_HOLD(2), .WIN(8), .CNT_W(2)) u1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   // latch: x!=z sets g, r clears it, one register of latency
   logic neq0 = 1'b0;
   logic ill0 = 1'b0;
   logic ack0 = 1'b0;
   logic g0   = 1'b0;

   always @(posedge clk) begin
      if (bus0.r === 1'b1) g0 <= 1'b0;
      else if (neq0)       g0 <= 1'b1;
   end

   assign bus0.g   = ill0 ? 1'b0 : g0;
   assign bus0.gn  = ill0 ? 1'b0 : ~g0;
   assign bus0.ack = ack0;

   logic g1 = 1'b0;
   logic gn1 = 1'b1;
   logic ack1 = 1'b0;
   assign bus1.g   = g1;
   assign bus1.gn  = gn1;
   assign bus1.ack = ack1;

   typedef struct {
      int         cyc;
      bit         inst;
      logic       r;
      logic       f;
      logic       i;
      logic [3:0] h;
      logic [7:0] e;
      string      name;
   } exp_t;

   exp_t q[$];
   int   cyc_cnt = 0;
   int   n_total = 0;
   int   n_bad   = 0;
   bit   done    = 1'b0;

   task automatic chk(input string nm, input bit inst, input logic er, input logic ef,
                      input logic ei, input logic [3:0] eh, input logic [7:0] ee);
      exp_t x;
      x.cyc  = cyc_cnt + 1;
      x.inst = inst;
      x.r    = er;
      x.f    = ef;
      x.i    = ei;
      x.h    = eh;
      x.e    = ee;
      x.name = nm;
      q.push_back(x);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic s0(input string nm, input logic er, input logic ef, input logic ei,
                     input logic [3:0] eh, input logic [7:0] ee);
      chk(nm, 1'b0, er, ef, ei, eh, ee);
   endtask

   task automatic s1(input string nm, input logic er, input logic ef,
                     input logic [3:0] eh, input logic [7:0] ee);
      chk(nm, 1'b1, er, ef, 1'b0, eh, ee);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // monitor: pops every expectation due at this edge and compares
   initial begin
      exp_t x;
      logic [14:0] act;
      logic [14:0] want;
      while (!done) begin
         @(posedge clk);
         cyc_cnt++;
         #1;
         while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
            x = q.pop_front();
            if (x.inst == 1'b0)
               act = {bus0.r, bus0.fault, bus0.illegal, bus0.hits, bus0.err_cnt};
            else
               act = {bus1.r, bus1.fault, bus1.illegal, bus1.hits, 6'd0, bus1.err_cnt};
            want = {x.r, x.f, x.i, x.h, x.e};
            n_total++;
            if (act !== want || x.cyc != cyc_cnt) begin
               n_bad++;
               $display("FAIL %s inst=%0d cyc=%0d got r=%b f=%b i=%b h=%0d e=%0d want r=%b f=%b i=%b h=%0d e=%0d",
                        x.name, x.inst, cyc_cnt, act[14], act[13], act[12], act[11:8], act[7:0],
                        x.r, x.f, x.i, x.h, x.e);
            end
         end
      end
      n_total++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL leftover got=%0d want=0", q.size());
      end
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end

   initial begin
      rst  = 1'b1;
      neq0 = 1'b1;
      @(negedge clk);

      // reset with mismatch pending, then transient episode
      s0("rst1", 0, 0, 0, 0, 0);
      s0("rst2", 0, 0, 0, 0, 0);
      rst  = 1'b0;
      neq0 = 1'b0;
      s0("rel_r", 1, 0, 0, 1, 0);
      s0("clr2", 1, 0, 0, 1, 0);
      repeat (8) s0("tr_wait", 0, 0, 0, 1, 0);
      s0("tr_idle", 0, 0, 0, 0, 0);
      s0("tr_noreassert", 0, 0, 0, 0, 0);

      // persistent mismatch escalates to fault
      neq0 = 1'b1;
      s0("p_idle", 0, 0, 0, 0, 0);
      s0("p_clr1a", 1, 0, 0, 1, 0);
      s0("p_clr1b", 1, 0, 0, 1, 0);
      s0("p_wait1a", 0, 0, 0, 1, 0);
      s0("p_wait1b", 0, 0, 0, 1, 0);
      s0("p_clr2a", 1, 0, 0, 2, 0);
      s0("p_clr2b", 1, 0, 0, 2, 0);
      ack0 = 1'b1;
      s0("p_ack_wait", 0, 0, 0, 2, 0);
      ack0 = 1'b0;
      s0("p_wait2b", 0, 0, 0, 2, 0);
      s0("p_fault", 0, 1, 0, 3, 1);
      s0("p_hold1", 0, 1, 0, 3, 1);
      s0("p_hold2", 0, 1, 0, 3, 1);

      // ack with mismatch still present re-runs the episode
      ack0 = 1'b1;
      s0("a_ack", 1, 0, 0, 1, 1);
      ack0 = 1'b0;
      s0("a_clr1b", 1, 0, 0, 1, 1);
      s0("a_wait1a", 0, 0, 0, 1, 1);
      s0("a_wait1b", 0, 0, 0, 1, 1);
      s0("a_clr2a", 1, 0, 0, 2, 1);
      s0("a_clr2b", 1, 0, 0, 2, 1);
      s0("a_wait2a", 0, 0, 0, 2, 1);
      s0("a_wait2b", 0, 0, 0, 2, 1);
      s0("a_fault", 0, 1, 0, 3, 2);
      s0("a_hold", 0, 1, 0, 3, 2);

      // illegal encoding, sticky until ack, set beats ack
      ill0 = 1'b1;
      s0("i_set", 0, 1, 1, 3, 2);
      ill0 = 1'b0;
      s0("i_sticky1", 0, 1, 1, 3, 2);
      s0("i_sticky2", 0, 1, 1, 3, 2);
      ill0 = 1'b1;
      ack0 = 1'b1;
      neq0 = 1'b0;
      s0("i_set_wins", 1, 0, 1, 1, 2);
      ill0 = 1'b0;
      s0("i_ack_clr", 1, 0, 0, 1, 2);
      ack0 = 1'b0;
      repeat (7) s0("i_wait", 0, 0, 0, 1, 2);
      neq0 = 1'b1;
      s0("i_wait_last", 0, 0, 0, 1, 2);
      s0("x_expiry_mm", 1, 0, 0, 2, 2);
      s0("x_clr2b", 1, 0, 0, 2, 2);
      s0("x_wait_a", 0, 0, 0, 2, 2);
      s0("x_wait_b", 0, 0, 0, 2, 2);
      s0("x_fault", 0, 1, 0, 3, 3);

      // reset in the second r cycle of a clear
      ack0 = 1'b1;
      s0("m_ack", 1, 0, 0, 1, 3);
      ack0 = 1'b0;
      s0("m_clr2", 1, 0, 0, 1, 3);
      rst  = 1'b1;
      neq0 = 1'b0;
      s0("m_rst", 0, 0, 0, 0, 0);
      rst  = 1'b0;
      s0("m_idle1", 0, 0, 0, 0, 0);
      s0("m_idle2", 0, 0, 0, 0, 0);

      // CNT_W=2 instance, g held high: settle sample ignored, counter saturates
      g1  = 1'b1;
      gn1 = 1'b0;
      s1("s_clr1a", 1, 0, 1, 0);
      s1("s_clr1b", 1, 0, 1, 0);
      s1("s_wait1a", 0, 0, 1, 0);
      s1("s_settle", 0, 0, 1, 0);
      s1("s_clr2a", 1, 0, 2, 0);
      s1("s_clr2b", 1, 0, 2, 0);
      s1("s_wait2a", 0, 0, 2, 0);
      s1("s_wait2b", 0, 0, 2, 0);
      s1("s_fault1", 0, 1, 3, 1);
      s1("s_hold", 0, 1, 3, 1);
      for (int k = 0; k < 4; k++) begin
         ack1 = 1'b1;
         s1("s_ack", 1, 0, 1, (k + 1 > 3) ? 8'd3 : 8'(k + 1));
         ack1 = 1'b0;
         repeat (7) tick();
         s1("s_fault_n", 0, 1, 3, (k + 2 > 3) ? 8'd3 : 8'(k + 2));
      end
      g1  = 1'b0;
      gn1 = 1'b1;

      tick();
      done = 1'b1;
   end
endmodule
